// File: rtl/rr_arb_buff_if.sv
// Valid/ready data channel shared by the arbiter inputs and its output.
// master drives data/valid and samples ready; slave does the reverse.
interface rr_arb_buff_if #(
    parameter int DW = 16
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/rr_arb_buff.sv
// Round-robin arbiter feeding a single-entry registered output stage.
// Each accepted beat is tagged with the index of the input that supplied it
// (index in the MSBs). With LOCK=1 the data MSB is an end-of-transaction flag
// and the grant stays on one input until a beat with that flag set is taken,
// so multi-beat packets reach the consumer without interleaving.
module rr_arb_buff #(
    parameter  int NUM   = 2,
    parameter  int W     = 16,
    parameter  int LOCK  = 0,
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    rr_arb_buff_if.slave  din [NUM],
    rr_arb_buff_if.master dout
);

    // Index arithmetic modulo NUM: base + off, wrapping back to 0.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM) begin
            s = s - NUM;
        end else begin
            s = s;
        end
        return s[IDX_W-1:0];
    endfunction

    // Flattened copies of the input channels.
    logic [NUM-1:0] w_valid;
    logic [W-1:0]   w_data [NUM];
    logic [NUM-1:0] w_ready;

    // Arbitration results.
    logic [IDX_W-1:0] w_grant;
    logic             w_grant_ok;
    logic [W-1:0]     w_sel_data;
    logic             w_can_load;
    logic             w_xfer;
    logic             w_hold;

    // Output register, round-robin pointer and packet lock.
    logic             r_valid;
    logic [IDX_W+W-1:0] r_data;
    logic [IDX_W-1:0] r_ptr;
    logic             r_lock;
    logic [IDX_W-1:0] r_lock_idx;

    for (genvar i = 0; i < NUM; i++) begin : g_in
        assign w_valid[i]   = din[i].valid;
        assign w_data[i]    = din[i].data;
        assign din[i].ready = w_ready[i];

        if ($bits(din[i].data) != W) begin : g_bad_din_w
            $error("rr_arb_buff: din[%0d] data width %0d differs from W=%0d", i, $bits(din[i].data), W);
        end
    end

    if ($bits(dout.data) != IDX_W + W) begin : g_bad_dout_w
        $error("rr_arb_buff: dout data width %0d differs from IDX_W+W=%0d", $bits(dout.data), IDX_W + W);
    end

    if ((LOCK != 0) && (W < 2)) begin : g_bad_lock_w
        $error("rr_arb_buff: LOCK=1 needs W>=2 so the eot flag leaves room for data");
    end

    // Grant selection: locked input only while a packet is open, otherwise
    // the first valid input at or after the round-robin pointer.
    always_comb begin
        w_grant    = {IDX_W{1'b0}};
        w_grant_ok = 1'b0;
        if (r_lock) begin
            w_grant    = r_lock_idx;
            w_grant_ok = w_valid[r_lock_idx];
        end else begin
            for (int k = 0; k < NUM; k++) begin
                if (!w_grant_ok && w_valid[wrap_add(r_ptr, k)]) begin
                    w_grant    = wrap_add(r_ptr, k);
                    w_grant_ok = 1'b1;
                end else begin
                    w_grant_ok = w_grant_ok;
                end
            end
        end
    end

    // Data mux for the granted input.
    always_comb begin
        w_sel_data = {W{1'b0}};
        for (int i = 0; i < NUM; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_sel_data = w_data[i];
            end else begin
                w_sel_data = w_sel_data;
            end
        end
    end

    // Handshake: only the granted input sees ready, and only when the
    // output register is empty or being emptied this cycle.
    always_comb begin
        w_can_load = ~r_valid | dout.ready;
        w_xfer     = w_can_load & w_grant_ok & ~rst;
        w_hold     = (LOCK != 0) ? ~w_sel_data[W-1] : 1'b0;
        w_ready    = {NUM{1'b0}};
        for (int i = 0; i < NUM; i++) begin
            w_ready[i] = w_xfer & (w_grant == IDX_W'(i));
        end
    end

    // Output register load/drain, pointer advance and lock tracking.
    // A beat without eot opens (or keeps) the lock and leaves the pointer
    // alone; a closing or unlocked beat moves the pointer past its input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data     <= {(IDX_W + W){1'b0}};
            r_ptr      <= {IDX_W{1'b0}};
            r_lock     <= 1'b0;
            r_lock_idx <= {IDX_W{1'b0}};
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= {w_grant, w_sel_data};
            if (w_hold) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant;
            end else begin
                r_lock <= 1'b0;
                r_ptr  <= wrap_add(w_grant, 1);
            end
        end else if (dout.ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign dout.valid = r_valid;
    assign dout.data  = r_data;

endmodule

// File: tb/tb_rr_arb_buff.sv
// Bench for rr_arb_buff: a NUM=3/W=8/LOCK=0 instance and a NUM=2/W=9/LOCK=1
// instance share clock and reset. A directed table, two reset sequences and
// random traffic are all checked against a behavioural model.
module tb_rr_arb_buff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0] in_v  [2];
    logic [8:0] in_d  [2][3];
    logic       in_dr [2];
    logic [2:0] rdy0;
    logic [1:0] rdy1;

    rr_arb_buff_if #(.DW(8))  d0_in [3] ();
    rr_arb_buff_if #(.DW(10)) d0_out ();
    rr_arb_buff_if #(.DW(9))  d1_in [2] ();
    rr_arb_buff_if #(.DW(10)) d1_out ();

    for (genvar i = 0; i < 3; i++) begin : g_d0
        assign d0_in[i].valid = in_v[0][i];
        assign d0_in[i].data  = in_d[0][i][7:0];
        assign rdy0[i]        = d0_in[i].ready;
    end
    for (genvar i = 0; i < 2; i++) begin : g_d1
        assign d1_in[i].valid = in_v[1][i];
        assign d1_in[i].data  = in_d[1][i];
        assign rdy1[i]        = d1_in[i].ready;
    end
    assign d0_out.ready = in_dr[0];
    assign d1_out.ready = in_dr[1];

    rr_arb_buff #(.NUM(3), .W(8), .LOCK(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .din (d0_in),
        .dout(d0_out)
    );

    rr_arb_buff #(.NUM(2), .W(9), .LOCK(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .din (d1_in),
        .dout(d1_out)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         sel;
        logic [2:0] v;
        logic [8:0] d0, d1, d2;
        logic       dr;
        logic [2:0] exp_rdy;
        logic       exp_ov;
        logic [9:0] exp_od;
    } vec_t;

    vec_t tab [$];
    vec_t nov;

    // Reference model state, one slot per instance.
    int         m_ptr  [2];
    bit         m_lock [2];
    int         m_lidx [2];
    bit         m_ov   [2];
    logic [9:0] m_od   [2];
    int         m_g    [2];
    bit         m_can  [2];

    function automatic int num_of(input int u); return (u == 0) ? 3 : 2; endfunction
    function automatic int wb_of(input int u);  return (u == 0) ? 8 : 9; endfunction

    function automatic logic [2:0] get_rdy(input int u);
        return (u == 0) ? rdy0 : {1'b0, rdy1};
    endfunction
    function automatic logic got_ov(input int u);
        return (u == 0) ? d0_out.valid : d1_out.valid;
    endfunction
    function automatic logic [9:0] got_od(input int u);
        return (u == 0) ? d0_out.data : d1_out.data;
    endfunction

    function automatic vec_t mk(input int sel, input logic [2:0] v, input logic [8:0] a,
                                input logic [8:0] b, input logic [8:0] c, input logic dr,
                                input logic [2:0] er, input logic eov, input logic [9:0] eod);
        vec_t r;
        r.sel = sel; r.v = v; r.d0 = a; r.d1 = b; r.d2 = c; r.dr = dr;
        r.exp_rdy = er; r.exp_ov = eov; r.exp_od = eod;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_ptr[u] = 0; m_lock[u] = 1'b0; m_lidx[u] = 0; m_ov[u] = 1'b0; m_od[u] = 10'h000;
        end
    endtask

    // Which input wins this cycle, or -1 for none.
    function automatic int m_grant(input int u);
        if (m_lock[u]) return in_v[u][m_lidx[u]] ? m_lidx[u] : -1;
        for (int k = 0; k < num_of(u); k++) begin
            if (in_v[u][(m_ptr[u] + k) % num_of(u)]) return (m_ptr[u] + k) % num_of(u);
        end
        return -1;
    endfunction

    task automatic pre_check();
        logic [2:0] er;
        for (int u = 0; u < 2; u++) begin
            m_can[u] = !m_ov[u] || in_dr[u];
            m_g[u]   = m_grant(u);
            er = 3'b000;
            if (!rst && m_can[u] && m_g[u] >= 0) er[m_g[u]] = 1'b1;
            chk($sformatf("ready_u%0d", u), 32'(get_rdy(u)), 32'(er));
        end
    endtask

    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_ptr[u] = 0; m_lock[u] = 1'b0; m_lidx[u] = 0; m_ov[u] = 1'b0;
            end else if (m_can[u] && m_g[u] >= 0) begin
                m_ov[u] = 1'b1;
                m_od[u] = 10'((m_g[u] << wb_of(u)) | (int'(in_d[u][m_g[u]]) & ((1 << wb_of(u)) - 1)));
                if (u == 1 && !in_d[u][m_g[u]][8]) begin
                    m_lock[u] = 1'b1; m_lidx[u] = m_g[u];
                end else begin
                    m_lock[u] = 1'b0; m_ptr[u] = (m_g[u] + 1) % num_of(u);
                end
            end else if (in_dr[u]) begin
                m_ov[u] = 1'b0;
            end
        end
    endtask

    task automatic post_check();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("dout_valid_u%0d", u), 32'(got_ov(u)), 32'(m_ov[u]));
            if (m_ov[u]) chk($sformatf("dout_data_u%0d", u), 32'(got_od(u)), 32'(m_od[u]));
        end
    endtask

    // One clock cycle, entered just after a falling edge with inputs driven.
    task automatic cycle(input bit use_tab, input vec_t e);
        #1;
        pre_check();
        if (use_tab) chk("tab_ready", 32'(get_rdy(e.sel)), 32'(e.exp_rdy));
        @(posedge clk);
        model_step();
        #1;
        post_check();
        if (use_tab) begin
            chk("tab_valid", 32'(got_ov(e.sel)), 32'(e.exp_ov));
            if (e.exp_ov) chk("tab_data", 32'(got_od(e.sel)), 32'(e.exp_od));
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int u = 0; u < 2; u++) begin
            in_v[u] = 3'b000; in_dr[u] = 1'b1;
            for (int i = 0; i < 3; i++) in_d[u][i] = 9'h000;
        end
    endtask

    initial begin
        nov = mk(0, 3'b000, 9'h0, 9'h0, 9'h0, 1'b1, 3'b000, 1'b0, 10'h0);
        // Instance 0: rotation, lone input 2, backpressure hold.
        for (int k = 0; k < 6; k++) begin
            tab.push_back(mk(0, 3'b111, 9'(16 + k), 9'(32 + k), 9'(48 + k), 1'b1,
                             3'(1 << (k % 3)), 1'b1, 10'(((k % 3) << 8) | (16 * ((k % 3) + 1) + k))));
        end
        tab.push_back(mk(0, 3'b100, 9'h0, 9'h0, 9'h011, 1'b1, 3'b100, 1'b1, 10'h211));
        tab.push_back(mk(0, 3'b100, 9'h0, 9'h0, 9'h022, 1'b1, 3'b100, 1'b1, 10'h222));
        tab.push_back(mk(0, 3'b100, 9'h0, 9'h0, 9'h033, 1'b1, 3'b100, 1'b1, 10'h233));
        tab.push_back(mk(0, 3'b010, 9'h0, 9'h0A5, 9'h0, 1'b1, 3'b010, 1'b1, 10'h1A5));
        for (int k = 0; k < 4; k++)
            tab.push_back(mk(0, 3'b111, 9'h001, 9'h002, 9'h003, 1'b0, 3'b000, 1'b1, 10'h1A5));
        tab.push_back(mk(0, 3'b111, 9'h001, 9'h002, 9'h003, 1'b1, 3'b100, 1'b1, 10'h203));
        tab.push_back(mk(0, 3'b000, 9'h0, 9'h0, 9'h0, 1'b1, 3'b000, 1'b0, 10'h000));
        // Instance 1: single beat on 0, locked 3-beat packet on 1 with a gap, then 0.
        tab.push_back(mk(1, 3'b011, 9'h100, 9'h0A1, 9'h0, 1'b1, 3'b001, 1'b1, 10'h100));
        tab.push_back(mk(1, 3'b011, 9'h105, 9'h0A1, 9'h0, 1'b1, 3'b010, 1'b1, 10'h2A1));
        tab.push_back(mk(1, 3'b001, 9'h105, 9'h0A2, 9'h0, 1'b1, 3'b000, 1'b0, 10'h000));
        tab.push_back(mk(1, 3'b011, 9'h105, 9'h0A2, 9'h0, 1'b1, 3'b010, 1'b1, 10'h2A2));
        tab.push_back(mk(1, 3'b011, 9'h105, 9'h1A3, 9'h0, 1'b1, 3'b010, 1'b1, 10'h3A3));
        tab.push_back(mk(1, 3'b011, 9'h105, 9'h0A1, 9'h0, 1'b1, 3'b001, 1'b1, 10'h105));

        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        // Held in reset with every input valid: no ready, nothing buffered.
        in_v[0] = 3'b111; in_v[1] = 3'b011;
        cycle(1'b0, nov);
        rst = 1'b0;
        idle_inputs();

        foreach (tab[n]) begin
            idle_inputs();
            in_v[tab[n].sel]     = tab[n].v;
            in_d[tab[n].sel][0]  = tab[n].d0;
            in_d[tab[n].sel][1]  = tab[n].d1;
            in_d[tab[n].sel][2]  = tab[n].d2;
            in_dr[tab[n].sel]    = tab[n].dr;
            cycle(1'b1, tab[n]);
        end

        // Open a packet on instance 1 while instance 0 streams, then reset
        // asynchronously between clock edges.
        idle_inputs();
        in_v[0] = 3'b111; in_d[0][0] = 9'h055; in_d[0][1] = 9'h066; in_d[0][2] = 9'h077;
        in_v[1] = 3'b010; in_d[1][1] = 9'h0C1;
        cycle(1'b0, nov);
        in_v[1] = 3'b011; in_d[1][0] = 9'h1B0; in_d[1][1] = 9'h0C2;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dout_valid_u0", 32'(d0_out.valid), 32'd0);
        chk("async_rst_dout_valid_u1", 32'(d1_out.valid), 32'd0);
        chk("async_rst_ready_u1", 32'(rdy1), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, nov);
        chk("post_rst_grant_u0", 32'(d0_out.data), 32'h055);
        chk("post_rst_unlocked_u1", 32'(d1_out.data), 32'h1B0);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int u = 0; u < 2; u++) begin
                in_v[u]  = 3'($urandom) & ((u == 0) ? 3'b111 : 3'b011);
                in_dr[u] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 3; i++) begin
                    in_d[u][i] = 9'($urandom);
                    if (u == 1) in_d[u][i][8] = ($urandom_range(0, 2) == 0);
                end
            end
            cycle(1'b0, nov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
